// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor
// and the ALU status word built from its flags.
package cla_addsub_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit two-level carry-lookahead block.
// Every carry is a flat sum of products of G, P and the group carry-in.
module cla_group
  import cla_addsub_pipe_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             term;
  logic             prod;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] = G[i-1] | P[i-1]G[i-2] | ... | P[i-1..0]ci
  always_comb begin
    c    = '0;
    term = 1'b0;
    prod = 1'b0;
    c[0] = ci;
    for (int i = 1; i <= GROUP; i++) begin
      term = ci;
      for (int m = 0; m < i; m++) begin
        term = term & p[m];
      end
      for (int j = 0; j < i; j++) begin
        prod = g[j];
        for (int m = j + 1; m < i; m++) begin
          prod = prod & p[m];
        end
        term = term | prod;
      end
      c[i] = term;
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign co    = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group per
// stage, carry handed stage to stage, valid/ready with global stall.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = WIDTH / GROUP;

  if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a positive multiple of GROUP");
  end

  logic             adv;
  logic             sub_en;
  logic [WIDTH-1:0] bb;
  logic             cin_eff;

  logic [NGRP-1:0]  vld_q;
  logic [NGRP-1:0]  co_q;
  logic [WIDTH-1:0] a_q   [NGRP];
  logic [WIDTH-1:0] bb_q  [NGRP];
  logic [WIDTH-1:0] sum_q [NGRP];
  logic [WIDTH-1:0] sum_d [NGRP];
  logic             ovf_q;
  logic             ovf_d;
  logic             zero_q;
  logic             zero_d;

  logic [GROUP-1:0] ga [NGRP];
  logic [GROUP-1:0] gb [NGRP];
  logic [GROUP-1:0] gs [NGRP];
  logic             gcm [NGRP];
  logic [NGRP-1:0]  gci;
  logic [NGRP-1:0]  gco;

  assign adv      = !vld_q[NGRP-1] | out_ready;
  assign in_ready = adv;

  assign sub_en  = (sub == MODE_SUB);
  assign bb      = b ^ {WIDTH{sub_en}};
  assign cin_eff = c_in ^ sub_en;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ga[k]  = a[GROUP-1:0];
      assign gb[k]  = bb[GROUP-1:0];
      assign gci[k] = cin_eff;
    end else begin : g_tail
      assign ga[k]  = a_q[k-1][k*GROUP +: GROUP];
      assign gb[k]  = bb_q[k-1][k*GROUP +: GROUP];
      assign gci[k] = co_q[k-1];
    end

    cla_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a    (ga[k]),
      .b    (gb[k]),
      .ci   (gci[k]),
      .s    (gs[k]),
      .co   (gco[k]),
      .c_msb(gcm[k])
    );
  end

  // Each stage overlays its freshly resolved group onto the upstream sum
  always_comb begin
    sum_d[0] = '0;
    sum_d[0][GROUP-1:0] = gs[0];
    for (int k = 1; k < NGRP; k++) begin
      sum_d[k] = sum_q[k-1];
      sum_d[k][k*GROUP +: GROUP] = gs[k];
    end
  end

  assign ovf_d  = gcm[NGRP-1] ^ gco[NGRP-1];
  assign zero_d = (sum_d[NGRP-1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      co_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NGRP; k++) begin
        a_q[k]   <= '0;
        bb_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      bb_q[0]  <= bb;
      for (int k = 1; k < NGRP; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        bb_q[k]  <= bb_q[k-1];
      end
      for (int k = 0; k < NGRP; k++) begin
        sum_q[k] <= sum_d[k];
      end
      co_q   <= gco;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = vld_q[NGRP-1];
  assign sum       = sum_q[NGRP-1];
  assign c_out     = co_q[NGRP-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
